seg7_scan_driver: RTL and testbench

- Time-multiplexed, parametrised driver for NUM_DIGITS hex seven-segment digits.
- Full hex decode (0-F) with per-digit decimal point, leading-zero blanking, per-digit blink and configurable segment/digit polarity.
- Double-buffered: a new value takes effect only at a frame boundary, so the display never tears.
- Sits between HPS/FPGA status registers and the board display pins.

---
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex seven-segment driver with double-buffered display content,
// leading-zero blanking, per-digit blink and configurable pin polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz_en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_pulse
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // XOR masks applied last; they double as the "unlit / deasserted" reset values.
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [FRM_W-1:0]        r_frm;
  logic                    r_blink_phase;
  logic                    r_pending;

  logic [4*NUM_DIGITS-1:0] r_act_val, r_shd_val;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_shd_dp;
  logic [NUM_DIGITS-1:0]   r_act_blink, r_shd_blink;
  logic                    r_act_lz, r_shd_lz;

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame_pulse;

  logic                    w_slot_end;
  logic                    w_boundary;
  logic                    w_guard;
  logic                    w_blinked;
  logic                    w_lz;
  logic [4*NUM_DIGITS-1:0] w_val_sh;
  logic [NUM_DIGITS-1:0]   w_dp_sh;
  logic [NUM_DIGITS-1:0]   w_bl_sh;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg_hi;
  logic                    w_dp_hi;
  logic [NUM_DIGITS-1:0]   w_dig_hi;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

  always_comb begin
    // Shifting the selected digit down to bit 0 also makes the leading-zero
    // test trivial: the digit is blank when nothing remains at or above it.
    w_val_sh  = r_act_val >> {r_idx, 2'b00};
    w_dp_sh   = r_act_dp >> r_idx;
    w_bl_sh   = r_act_blink >> r_idx;
    w_onehot  = NUM_DIGITS'(1) << r_idx;
    w_guard   = (r_cnt < CNT_GUARD);
    w_blinked = r_blink_phase && w_bl_sh[0];
    w_lz      = r_act_lz && (r_idx != '0) && (w_val_sh == '0);
    w_seg_hi  = (w_guard || w_blinked || w_lz) ? 7'h00 : hex_to_seg(w_val_sh[3:0]);
    w_dp_hi   = !w_guard && !w_blinked && w_dp_sh[0];
    w_dig_hi  = w_guard ? '0 : w_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frm         <= '0;
      r_blink_phase <= 1'b0;
      r_pending     <= 1'b0;
      r_act_val     <= '0;
      r_act_dp      <= '0;
      r_act_blink   <= '0;
      r_act_lz      <= 1'b0;
      r_shd_val     <= '0;
      r_shd_dp      <= '0;
      r_shd_blink   <= '0;
      r_shd_lz      <= 1'b0;
      r_seg         <= SEG_INV;
      r_dp          <= DP_INV;
      r_dig         <= DIG_INV;
      r_frame_pulse <= 1'b0;
    end else begin
      r_frame_pulse <= w_boundary;

      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_boundary) begin
        if (r_frm == FRM_LAST) begin
          r_frm         <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frm <= r_frm + 1'b1;
        end
      end

      // A load on the boundary bypasses the shadow so it is never lost.
      if (load && w_boundary) begin
        r_act_val   <= value;
        r_act_dp    <= dp_mask;
        r_act_blink <= blink_mask;
        r_act_lz    <= blank_lz_en;
        r_pending   <= 1'b0;
      end else if (load) begin
        r_shd_val   <= value;
        r_shd_dp    <= dp_mask;
        r_shd_blink <= blink_mask;
        r_shd_lz    <= blank_lz_en;
        r_pending   <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_act_val   <= r_shd_val;
        r_act_dp    <= r_shd_dp;
        r_act_blink <= r_shd_blink;
        r_act_lz    <= r_shd_lz;
        r_pending   <= 1'b0;
      end

      r_seg <= w_seg_hi ^ SEG_INV;
      r_dp  <= w_dp_hi ^ DP_INV;
      r_dig <= w_dig_hi ^ DIG_INV;
    end
  end

  assign seg_out     = r_seg;
  assign dp_out      = r_dp;
  assign digit_en    = r_dig;
  assign frame_pulse = r_frame_pulse;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level reference model queues the
// expected pins for every clock and a negedge monitor compares them.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = N * SD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  value = '0;
  logic [3:0]   dp_mask = '0;
  logic [3:0]   blink_mask = '0;
  logic         blank_lz_en = 1'b0;
  logic [6:0]   seg_out;
  logic         dp_out;
  logic [3:0]   digit_en;
  logic         frame_pulse;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .blank_lz_en(blank_lz_en), .seg_out(seg_out),
    .dp_out(dp_out), .digit_en(digit_en), .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
  } cfg_t;

  typedef struct packed {
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  den;
    logic        fp;
    logic [31:0] st;
  } exp_t;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   st = 0;
  cfg_t cur = '0;
  cfg_t nxt = '0;
  bit   nxt_v = 1'b0;

  // Pins expected after the clock edge that leaves state s (clocks since release).
  function automatic exp_t model_out(input cfg_t c, input int s);
    exp_t r;
    int pos, d, k, f;
    bit phase, blinked, lz;
    logic [3:0] nib;
    pos = s % FRAME;
    d   = pos / SD;
    k   = pos % SD;
    f   = s / FRAME;
    phase   = ((f / BF) % 2) == 1;
    nib     = c.v[4*d +: 4];
    blinked = phase && c.bl[d];
    lz      = c.lz && (d > 0);
    for (int j = d; j < N; j++)
      if (c.v[4*j +: 4] != 4'h0) lz = 1'b0;
    r.st = 32'(s);
    r.fp = (pos == FRAME - 1);
    if (k < GD) begin
      r.seg = 7'h7F;
      r.dp  = 1'b1;
      r.den = 4'hF;
    end else begin
      r.seg = (blinked || lz) ? 7'h7F : ~seg_tab[nib];
      r.dp  = !(c.dp[d] && !blinked);
      r.den = ~(4'b0001 << d);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                     input int s);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s state=%0d got=%h expected=%h", name, s, act, exp_v);
    end
  endtask

  // Reference model: content of frame f+1 is the last load seen during frame f.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      st    = 0;
      cur   = '0;
      nxt_v = 1'b0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out(cur, st));
      if (load) begin
        nxt   = '{v: value, dp: dp_mask, bl: blink_mask, lz: blank_lz_en};
        nxt_v = 1'b1;
      end
      if ((st % FRAME) == FRAME - 1) begin
        if (nxt_v) cur = nxt;
        nxt_v = 1'b0;
      end
      st++;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("seg_out", 32'(seg_out), 32'(e.seg), int'(e.st));
      chk("dp_out", 32'(dp_out), 32'(e.dp), int'(e.st));
      chk("digit_en", 32'(digit_en), 32'(e.den), int'(e.st));
      chk("frame_pulse", 32'(frame_pulse), 32'(e.fp), int'(e.st));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz);
    value       = v;
    dp_mask     = dp;
    blink_mask  = bl;
    blank_lz_en = lz;
    load        = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    while (((st % FRAME) != FRAME - 1) && (n < 2 * FRAME)) begin
      tick(1);
      n++;
    end
    if ((st % FRAME) != FRAME - 1) begin
      errors++;
      $display("FAIL wait_boundary got_state=%0d required_pos=%0d", st, FRAME - 1);
    end
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_seg"}, 32'(seg_out), 32'h7F, st);
    chk({tag, "_dp"}, 32'(dp_out), 32'h1, st);
    chk({tag, "_den"}, 32'(digit_en), 32'hF, st);
    chk({tag, "_fp"}, 32'(frame_pulse), 32'h0, st);
  endtask

  initial begin
    logic [15:0] rv;
    #12;
    chk_reset_pins("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2 * FRAME);

    do_load(16'h1234, 4'b0100, 4'b0000, 1'b0);
    tick(2 * FRAME);
    do_load(16'h0040, 4'b0000, 4'b0000, 1'b1);
    tick(2 * FRAME);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    tick(2 * FRAME);

    do_load(16'h1111, 4'b0001, 4'b0000, 1'b0);
    tick(3);
    do_load(16'h2222, 4'b0010, 4'b0000, 1'b0);
    tick(2 * FRAME);

    wait_boundary();
    do_load(16'h5678, 4'b1000, 4'b0000, 1'b0);
    tick(2 * FRAME);

    do_load(16'h8888, 4'b0000, 4'b0001, 1'b0);
    tick(8 * FRAME);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) wait_boundary();
      else tick($urandom_range(0, 40));
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      do_load(rv, 4'($urandom), 4'($urandom), 1'($urandom));
    end
    tick(3 * FRAME);

    tick(13);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_pins("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2 * FRAME);

    if (checks < 1000) begin
      errors++;
      $display("FAIL check_count got=%0d required_min=1000", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
